rect_draw_scheduler: RTL
========================

Name: rect_draw_scheduler

Overview:
Shares the single pixel-write port of the VGA adapter (x, y, colour, plot) between NREQ independent rectangle-draw requesters, for example apple draw, snake-segment draw and erase.
Each requester asks for one XDIM x YDIM filled rectangle at a base coordinate in a given colour.
The block arbitrates round-robin, then scans the rectangle one pixel per clock, clipping any pixel outside the 160x120 screen.
It sits between the game FSMs and the vga_adapter instance.

Parameters:
NREQ, 3, number of requesters (2..4)
XDIM, 10, rectangle width in pixels (1..16)
YDIM, 10, rectangle height in pixels (1..16)
XSCREEN, 160, horizontal screen size; pixel x >= XSCREEN is clipped
YSCREEN, 120, vertical screen size; pixel y >= YSCREEN is clipped

Ports:
clk  in  1  system clock (CLOCK_50)
reset  in  1  synchronous, active-high reset
req  in  NREQ  per-requester draw request, level, held until ack
x_in  in  8*NREQ  base x per requester; requester i uses bits [8i+7:8i]
y_in  in  7*NREQ  base y per requester; requester i uses bits [7i+6:7i]
colour_in  in  3*NREQ  colour per requester; requester i uses bits [3i+2:3i]
ack  out  NREQ  one-cycle pulse on the granted bit when its rectangle is finished
busy  out  1  high in DRAW and DONE
vga_x  out  8  pixel x to the adapter
vga_y  out  7  pixel y to the adapter
vga_colour  out  3  pixel colour to the adapter
plot  out  1  pixel write strobe to the adapter

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - state = IDLE; xc = yc = 0; base registers = 0; last_grant = NREQ-1, so requester 0 wins first.
  - Outputs: plot = 0, ack = 0, busy = 0, vga_x = 0, vga_y = 0, vga_colour = 0.
- Reset mid-operation: the draw aborts, no ack is issued, and the block is in IDLE on the next cycle.
- States: IDLE, DRAW, DONE.
- IDLE:
  - If req != 0, select the first set bit searching from (last_grant+1) mod NREQ upward with wrap.
  - At the clock edge, latch that requester's x, y and colour into bx, by, bc; record g; clear xc and yc; go to DRAW.
  - If req == 0, stay in IDLE.
  - plot = 0 throughout IDLE.
- DRAW:
  - Pixel address: sx = {1'b0,bx} + xc (9-bit); sy = {1'b0,by} + yc (8-bit).
  - vga_x = sx[7:0], vga_y = sy[6:0], vga_colour = bc.
  - plot = 1 only when sx < XSCREEN and sy < YSCREEN. Clipped pixels still take their cycle, so scan timing is fixed.
  - Each cycle: if xc != XDIM-1 then xc++. Otherwise xc = 0 and, if yc != YDIM-1, yc++.
  - When xc == XDIM-1 and yc == YDIM-1, go to DONE.
  - Scan order is row-major with x fastest. DRAW lasts exactly XDIM*YDIM cycles.
- DONE:
  - ack[g] = 1 for exactly this cycle; last_grant <= g; go to IDLE.
- Latency: req sampled in IDLE at cycle T; first pixel at T+1; ack at T+1+XDIM*YDIM.
- Back-to-back service: one IDLE cycle between jobs, so the period is XDIM*YDIM+2 cycles (102 with defaults).
- Requester rules:
  - req and the requester's coordinates and colour are sampled only in IDLE. Changes during DRAW are ignored.
  - Dropping req mid-draw does not cancel the job; ack still pulses.
  - A requester may hold req high through its own ack. The IDLE after DONE then re-arbitrates, and round-robin makes the others go first.
- Fairness: with all req bits held high, the grant order is 0,1,...,NREQ-1,0,...
- ack, plot, vga_x, vga_y and vga_colour are driven combinationally from the state and registers; there are no registered output stages.
- Width rules:
  - sx must not wrap at 8 bits. Example: base 250 + 9 = 259, which is clipped, not drawn at x = 3.
  - sy likewise must not wrap at 7 bits.

Test Plan:
- Reset, then req=001 with x=30, y=30, colour=4 → 100 plot pulses from (30,30) to (39,39) in row-major order, colour 4; ack=001 at cycle 102 after req; busy high for 101 cycles.
- req=111 held continuously → grants in order 0,1,2,0 with starts at cycles 1, 103, 205, 307; each ack is a one-cycle pulse on the correct bit.
- Requester 1 only, x=155, y=115 → exactly 25 plots (x 155..159, y 115..119); ack still at cycle 102.
- Requester 2, x=250, y=0 → 0 plots (no wrapped pixel at x 0..3); ack at cycle 102.
- req0 dropped and x_in changed at pixel 20 → remaining pixels use the latched base, and ack[0] still pulses; reset asserted at pixel 50 → plot=0 next cycle, no ack, IDLE.
- With last_grant=0, req=011 → requester 1 granted first, then requester 0.

Source files
------------

// File: rtl/rect_draw_scheduler_if.sv
// Pixel-port sharing bus between rectangle requesters and the scheduler.
// Carries per-requester draw requests in, and the VGA pixel port plus acks out.
// The slave modport is the scheduler; the master modport is the requester side.
interface rect_draw_scheduler_if #(
   parameter int NREQ = 3
);
   logic [NREQ-1:0]   req;
   logic [8*NREQ-1:0] x_in;
   logic [7*NREQ-1:0] y_in;
   logic [3*NREQ-1:0] colour_in;
   logic [NREQ-1:0]   ack;
   logic              busy;
   logic [7:0]        vga_x;
   logic [6:0]        vga_y;
   logic [2:0]        vga_colour;
   logic              plot;

   modport master (
      output req, x_in, y_in, colour_in,
      input  ack, busy, vga_x, vga_y, vga_colour, plot
   );

   modport slave (
      input  req, x_in, y_in, colour_in,
      output ack, busy, vga_x, vga_y, vga_colour, plot
   );
endinterface

// File: rtl/rect_draw_scheduler.sv
// Round-robin shares the VGA pixel port between NREQ filled-rectangle requesters.
// Latency: grant sampled in IDLE, first pixel next cycle, ack XDIM*YDIM cycles later.
// Backpressure: req is level-held until ack; inputs are ignored while a rectangle draws.
module rect_draw_scheduler #(
   parameter int NREQ    = 3,
   parameter int XDIM    = 10,
   parameter int YDIM    = 10,
   parameter int XSCREEN = 160,
   parameter int YSCREEN = 120
) (
   input logic                  clk,
   input logic                  reset,
   rect_draw_scheduler_if.slave bus
);
   localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int NP = 1 << GW;
   localparam logic [3:0] XLAST = 4'(XDIM - 1);
   localparam logic [3:0] YLAST = 4'(YDIM - 1);
   localparam logic [8:0] XS    = 9'(XSCREEN);
   localparam logic [7:0] YS    = 8'(YSCREEN);

   typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

   state_t          r_state, w_next;
   logic [3:0]      r_xc, r_yc;
   logic [7:0]      r_bx;
   logic [6:0]      r_by;
   logic [2:0]      r_bc;
   logic [GW-1:0]   r_g, r_last;
   logic [GW-1:0]   w_sel, w_cand;
   logic            w_found;
   logic [NP-1:0]   w_req;
   logic [7:0]      w_x;
   logic [6:0]      w_y;
   logic [2:0]      w_c;
   logic [8:0]      w_sx;
   logic [7:0]      w_sy;
   logic            w_xend, w_yend;

   // Pad req to a power of two so a GW-bit index is always in range.
   assign w_req = NP'(bus.req);

   // Round-robin: first requesting bit after the last grant, wrapping.
   always_comb begin
      w_found = 1'b0;
      w_sel   = '0;
      w_cand  = '0;
      for (int k = 1; k <= NREQ; k++) begin
         w_cand = GW'((int'(r_last) + k) % NREQ);
         if (!w_found && w_req[w_cand]) begin
            w_found = 1'b1;
            w_sel   = w_cand;
         end
      end
   end

   // Select the winning requester's base coordinate and colour.
   always_comb begin
      w_x = '0;
      w_y = '0;
      w_c = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_sel == GW'(i)) begin
            w_x = bus.x_in[8*i +: 8];
            w_y = bus.y_in[7*i +: 7];
            w_c = bus.colour_in[3*i +: 3];
         end
      end
   end

   // Pixel address is one bit wider than the port so off-screen sums clip instead of wrapping.
   assign w_sx   = {1'b0, r_bx} + {5'b0, r_xc};
   assign w_sy   = {1'b0, r_by} + {4'b0, r_yc};
   assign w_xend = (r_xc == XLAST);
   assign w_yend = (r_yc == YLAST);

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   // Next-state: grant in IDLE, scan until the last pixel, one DONE cycle for the ack.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_found) w_next = DRAW;
         DRAW:    if (w_xend && w_yend) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Job registers: latch the grant, step the row-major scan, remember who went last.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_xc   <= '0;
         r_yc   <= '0;
         r_bx   <= '0;
         r_by   <= '0;
         r_bc   <= '0;
         r_g    <= '0;
         r_last <= GW'(NREQ - 1);
      end else begin
         case (r_state)
            IDLE: if (w_found) begin
               r_bx <= w_x;
               r_by <= w_y;
               r_bc <= w_c;
               r_g  <= w_sel;
               r_xc <= '0;
               r_yc <= '0;
            end
            DRAW: begin
               if (!w_xend) begin
                  r_xc <= r_xc + 4'd1;
               end else begin
                  r_xc <= '0;
                  if (!w_yend) r_yc <= r_yc + 4'd1;
               end
            end
            DONE:    r_last <= r_g;
            default: ;
         endcase
      end
   end

   // Unregistered pixel port and ack, derived from state and job registers.
   always_comb begin
      bus.plot       = (r_state == DRAW) && (w_sx < XS) && (w_sy < YS);
      bus.vga_x      = (r_state == DRAW) ? w_sx[7:0] : '0;
      bus.vga_y      = (r_state == DRAW) ? w_sy[6:0] : '0;
      bus.vga_colour = (r_state == DRAW) ? r_bc : '0;
      bus.busy       = (r_state != IDLE);
      for (int i = 0; i < NREQ; i++) begin
         bus.ack[i] = (r_state == DONE) && (r_g == GW'(i));
      end
   end
endmodule
